// File: rtl/dma_copia_memoria_if.sv
// Bus bundle between the DMA copy engine, the CPU (request/grant, control) and the data RAM.
// The master modport is the DMA side; the slave modport is the CPU/RAM side.
`timescale 1ns/1ps
interface dma_copia_memoria_if #(
    parameter int AW = 32,
    parameter int CW = 11
);
    logic          inicio;
    logic [AW-1:0] cfg_origen;
    logic [AW-1:0] cfg_destino;
    logic [CW-1:0] cfg_cantidad;
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] mem_dir;
    logic          mem_lectura;
    logic          mem_escritura;
    logic [31:0]   mem_dato_entrada;
    logic [31:0]   mem_dato_salida;
    logic          ocupado;
    logic          fin;
    logic          error;

    modport master (
        input  inicio, cfg_origen, cfg_destino, cfg_cantidad, bus_gnt, mem_dato_salida,
        output bus_req, mem_dir, mem_lectura, mem_escritura, mem_dato_entrada,
               ocupado, fin, error
    );

    modport slave (
        output inicio, cfg_origen, cfg_destino, cfg_cantidad, bus_gnt, mem_dato_salida,
        input  bus_req, mem_dir, mem_lectura, mem_escritura, mem_dato_entrada,
               ocupado, fin, error
    );
endinterface

// File: rtl/dma_copia_memoria.sv
// DMA block copy engine acting as second master on the data RAM (read on posedge, write on negedge).
// Optional completion interrupt (irq/irq_ack) enabled by defining DMA_IRQ_EN.
`timescale 1ns/1ps
module dma_copia_memoria #(
    parameter int AW   = 32,
    parameter int PROF = 1024,
    parameter int CW   = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    dma_copia_memoria_if.master bus
`ifdef DMA_IRQ_EN
    ,
    output logic                irq,
    input  logic                irq_ack
`endif
);

    typedef enum logic [2:0] {
        REPOSO,
        SOLICITUD,
        LEER,
        CAPTURA,
        ESCRIBIR,
        LIBERAR
    } estado_t;

    localparam logic [AW:0] LIMITE = (AW+1)'(PROF);

    estado_t       estado;
    estado_t       estado_sig;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [CW-1:0] cnt;
    logic [31:0]   buffer;
    logic          req_r;
    logic          ocupado_r;
    logic          fin_r;
    logic          error_r;

    logic          arranque;
    logic          cant_cero;
    logic          fuera_rango;
    logic          aceptado;
    logic          fin_sig;
    logic [AW:0]   cant_ext;
    logic [AW:0]   fin_origen;
    logic [AW:0]   fin_destino;

    // Bounds are evaluated one bit wider so a huge start address cannot wrap past the check.
    assign cant_ext    = (AW+1)'(bus.cfg_cantidad);
    assign fin_origen  = {1'b0, bus.cfg_origen}  + cant_ext;
    assign fin_destino = {1'b0, bus.cfg_destino} + cant_ext;
    assign arranque    = (estado == REPOSO) && bus.inicio;
    assign cant_cero   = (bus.cfg_cantidad == '0);
    assign fuera_rango = (fin_origen > LIMITE) || (fin_destino > LIMITE);
    assign aceptado    = arranque && !cant_cero && !fuera_rango;
    assign fin_sig     = (estado == LIBERAR) || (arranque && (cant_cero || fuera_rango));

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:    if (aceptado) estado_sig = SOLICITUD;
            SOLICITUD: if (bus.bus_gnt) estado_sig = LEER;
            LEER:      estado_sig = CAPTURA;
            CAPTURA:   estado_sig = ESCRIBIR;
            ESCRIBIR: begin
                if (cnt == CW'(1))     estado_sig = LIBERAR;
                else if (bus.bus_gnt)  estado_sig = LEER;
                else                   estado_sig = SOLICITUD;
            end
            LIBERAR:   estado_sig = REPOSO;
            default:   estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            req_r     <= 1'b0;
            ocupado_r <= 1'b0;
            fin_r     <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            estado <= estado_sig;
            fin_r  <= fin_sig;
            if (arranque) error_r <= !cant_cero && fuera_rango;
            // bus_req/ocupado stay up across paused word boundaries and drop together with fin.
            if (aceptado) begin
                req_r     <= 1'b1;
                ocupado_r <= 1'b1;
            end else if (estado == LIBERAR) begin
                req_r     <= 1'b0;
                ocupado_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            buffer  <= '0;
        end else begin
            if (aceptado) begin
                src_ptr <= bus.cfg_origen;
                dst_ptr <= bus.cfg_destino;
                cnt     <= bus.cfg_cantidad;
            end else if (estado == ESCRIBIR) begin
                src_ptr <= src_ptr + AW'(1);
                dst_ptr <= dst_ptr + AW'(1);
                cnt     <= cnt - CW'(1);
            end
            if (estado == CAPTURA) buffer <= bus.mem_dato_salida;
        end
    end

    always_comb begin
        bus.mem_dir          = '0;
        bus.mem_lectura      = 1'b0;
        bus.mem_escritura    = 1'b0;
        bus.mem_dato_entrada = '0;
        case (estado)
            LEER: begin
                bus.mem_dir     = src_ptr;
                bus.mem_lectura = 1'b1;
            end
            ESCRIBIR: begin
                bus.mem_dir          = dst_ptr;
                bus.mem_escritura    = 1'b1;
                bus.mem_dato_entrada = buffer;
            end
            default: ;
        endcase
    end

    assign bus.bus_req = req_r;
    assign bus.ocupado = ocupado_r;
    assign bus.fin     = fin_r;
    assign bus.error   = error_r;

`ifdef DMA_IRQ_EN
    // The set condition covers the whole fin cycle, so an ack coinciding with fin is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= fin_sig || fin_r || (irq && !irq_ack);
    end
`endif

endmodule

// File: tb/tb_dma_copia_memoria.sv
// Directed bench for dma_copia_memoria with a behavioural RAM (posedge read, negedge write).
// Define DMA_IRQ_EN for both bench and RTL to exercise the interrupt option.
`timescale 1ns/1ps
module tb_dma_copia_memoria;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_strobe;
    int   n_req;

    logic [31:0] ram [0:1023];
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    dma_copia_memoria_if #(.AW(32), .CW(11)) bus ();

`ifdef DMA_IRQ_EN
    logic irq;
    logic irq_ack;
`endif

    dma_copia_memoria #(.AW(32), .PROF(1024), .CW(11)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef DMA_IRQ_EN
        ,
        .irq     (irq),
        .irq_ack (irq_ack)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (bus.mem_escritura && bus.mem_dir < 32'd1024)
            ram[bus.mem_dir[9:0]] <= bus.mem_dato_entrada;
        if (bus.mem_lectura || bus.mem_escritura) n_strobe <= n_strobe + 1;
        if (bus.bus_req) n_req <= n_req + 1;
    end

    always @(posedge clk) begin
        if (bus.mem_lectura && bus.mem_dir < 32'd1024)
            bus.mem_dato_salida <= ram[bus.mem_dir[9:0]];
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic preload(input int base, input int n, input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            pre_addr = 10'(base + i);
            pre_data = seed + 32'(i);
            pre_we   = 1'b1;
            @(negedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] o, input logic [31:0] d, input logic [10:0] n);
        bus.cfg_origen   = o;
        bus.cfg_destino  = d;
        bus.cfg_cantidad = n;
        bus.inicio       = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio       = 1'b0;
    endtask

    task automatic wait_fin(inout int lat, output logic req_prev);
        req_prev = 1'b0;
        while (bus.fin !== 1'b1 && lat < 200) begin
            req_prev = bus.bus_req;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [36:0] obs;
        rst_n = 1'b0;
        #2;
        obs = {bus.bus_req, bus.ocupado, bus.fin, bus.error, bus.mem_lectura, bus.mem_dir};
        checks++;
        if (obs !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", obs);
        end
        checks++;
        if (bus.mem_escritura !== 1'b0 || bus.mem_dato_entrada !== 32'd0) begin
            errors++;
            $display("FAIL reset_write got %b/%h expected 0/0", bus.mem_escritura, bus.mem_dato_entrada);
        end
`ifdef DMA_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b expected 0", irq);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_copia_basica;
        int   lat;
        int   s0;
        logic rp;
        logic ok;
        preload(10, 4, pat(0));
        preload(500, 4, 32'd0);
        preload(900, 2, 32'hDEAD_0900);
        s0 = n_strobe;
        start(32'd10, 32'd500, 11'd4);
        lat = 1;
        // A second start while busy must be ignored.
        bus.cfg_destino  = 32'd900;
        bus.cfg_cantidad = 11'd2;
        bus.inicio       = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        lat = 2;
        wait_fin(lat, rp);
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 15", lat);
        end
        checks++;
        if (rp !== 1'b1 || bus.bus_req !== 1'b0 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL basic_req_drop got prev=%b req=%b ocup=%b expected 1/0/0", rp, bus.bus_req, bus.ocupado);
        end
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL basic_error got %b expected 0", bus.error);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.fin !== 1'b0) begin
            errors++;
            $display("FAIL basic_fin_pulse got %b expected 0", bus.fin);
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (ram[500+i] !== pat(i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_data got %h %h %h %h expected %h..%h", ram[500], ram[501], ram[502], ram[503], pat(0), pat(3));
        end
        checks++;
        if (ram[900] !== 32'hDEAD_0900) begin
            errors++;
            $display("FAIL basic_busy_start got %h expected DEAD0900", ram[900]);
        end
        checks++;
        if (n_strobe - s0 !== 8) begin
            errors++;
            $display("FAIL basic_strobes got %0d expected 8", n_strobe - s0);
        end
    endtask

    task automatic test_cantidad_cero;
        int   lat;
        int   r0;
        logic rp;
        preload(300, 1, 32'h5555_0300);
        r0 = n_req;
        start(32'd10, 32'd300, 11'd0);
        lat = 1;
        wait_fin(lat, rp);
        checks++;
        if (lat !== 1 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL zero_fin got lat=%0d err=%b expected 1/0", lat, bus.error);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (n_req - r0 !== 0 || ram[300] !== 32'h5555_0300) begin
            errors++;
            $display("FAIL zero_nobus got req_cycles=%0d ram=%h expected 0/55550300", n_req - r0, ram[300]);
        end
    endtask

    task automatic test_error_rango;
        int   lat;
        int   s0;
        int   r0;
        logic rp;
        logic ok;
        preload(1020, 4, pat(1020));
        s0 = n_strobe;
        r0 = n_req;
        start(32'd1020, 32'd100, 11'd5);
        lat = 1;
        wait_fin(lat, rp);
        checks++;
        if (lat !== 1 || bus.error !== 1'b1) begin
            errors++;
            $display("FAIL err_src got lat=%0d err=%b expected 1/1", lat, bus.error);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.error !== 1'b1 || n_strobe - s0 !== 0 || n_req - r0 !== 0) begin
            errors++;
            $display("FAIL err_sticky got err=%b strobes=%0d req=%0d expected 1/0/0", bus.error, n_strobe - s0, n_req - r0);
        end
        start(32'd0, 32'd1021, 11'd4);
        checks++;
        if (bus.error !== 1'b1 || bus.fin !== 1'b1 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL err_dst got err=%b fin=%b ocup=%b expected 1/1/0", bus.error, bus.fin, bus.ocupado);
        end
        @(posedge clk);
        #1;
        // Exactly reaching the top of memory is legal.
        start(32'd1020, 32'd700, 11'd4);
        checks++;
        if (bus.error !== 1'b0 || bus.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b ocup=%b expected 0/1", bus.error, bus.ocupado);
        end
        lat = 1;
        wait_fin(lat, rp);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (ram[700+i] !== pat(1020 + i)) ok = 1'b0;
        checks++;
        if (lat !== 15 || !ok) begin
            errors++;
            $display("FAIL err_edge_copy got lat=%0d data_ok=%b expected 15/1", lat, ok);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pausa_grant;
        int   c;
        int   bad;
        logic ok;
        preload(40, 8, pat(40));
        bus.bus_gnt = 1'b1;
        start(32'd40, 32'd200, 11'd8);
        c   = 1;
        bad = 0;
        while (bus.fin !== 1'b1 && c < 200) begin
            if (c == 10) bus.bus_gnt = 1'b0;
            if (c == 17) bus.bus_gnt = 1'b1;
            if (c >= 11 && c <= 17)
                if (bus.mem_lectura || bus.mem_escritura || !bus.bus_req) bad++;
            @(posedge clk);
            #1;
            c++;
        end
        bus.bus_gnt = 1'b1;
        checks++;
        if (c !== 34) begin
            errors++;
            $display("FAIL pause_latency got %0d expected 34", c);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL pause_idle got %0d bad cycles expected 0", bad);
        end
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (ram[200+i] !== pat(40 + i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pause_data got %h..%h expected %h..%h", ram[200], ram[207], pat(40), pat(47));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_asincrono;
        int          lat;
        logic        rp;
        logic        ok;
        logic [37:0] obs;
        preload(20, 4, pat(20));
        preload(600, 4, 32'hBEEF_0600);
        start(32'd20, 32'd600, 11'd4);
        for (int c = 1; c < 7; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.mem_escritura !== 1'b1 || bus.mem_dir !== 32'd601) begin
            errors++;
            $display("FAIL rst_setup got we=%b dir=%0d expected 1/601", bus.mem_escritura, bus.mem_dir);
        end
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bus.bus_req, bus.ocupado, bus.fin, bus.error, bus.mem_lectura, bus.mem_escritura, bus.mem_dir};
        checks++;
        if (obs !== 38'd0 || bus.mem_dato_entrada !== 32'd0) begin
            errors++;
            $display("FAIL rst_async got %h/%h expected 0/0", obs, bus.mem_dato_entrada);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ram[600] !== pat(20) || ram[601] !== 32'hBEEF_0601) begin
            errors++;
            $display("FAIL rst_abandon got %h %h expected %h BEEF0601", ram[600], ram[601], pat(20));
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(32'd20, 32'd600, 11'd4);
        lat = 1;
        wait_fin(lat, rp);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (ram[600+i] !== pat(20 + i)) ok = 1'b0;
        checks++;
        if (lat !== 15 || !ok) begin
            errors++;
            $display("FAIL rst_rerun got lat=%0d data_ok=%b expected 15/1", lat, ok);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef DMA_IRQ_EN
    task automatic test_irq;
        int   lat;
        logic rp;
        irq_ack = 1'b0;
        start(32'd10, 32'd800, 11'd2);
        lat = 1;
        wait_fin(lat, rp);
        checks++;
        if (lat !== 9 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got lat=%0d irq=%b expected 9/1", lat, irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold got %b expected 1", irq);
        end
        irq_ack = 1'b1;
        @(posedge clk);
        #1;
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack got %b expected 0", irq);
        end
        irq_ack = 1'b1;
        start(32'd10, 32'd810, 11'd1);
        lat = 1;
        wait_fin(lat, rp);
        @(posedge clk);
        #1;
        irq_ack = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got %b expected 1", irq);
        end
    endtask
`endif

    initial begin
        checks              = 0;
        errors              = 0;
        n_strobe            = 0;
        n_req               = 0;
        pre_we              = 1'b0;
        pre_addr            = '0;
        pre_data            = '0;
        rst_n               = 1'b1;
        bus.inicio          = 1'b0;
        bus.cfg_origen      = '0;
        bus.cfg_destino     = '0;
        bus.cfg_cantidad    = '0;
        bus.bus_gnt         = 1'b1;
        bus.mem_dato_salida = '0;
`ifdef DMA_IRQ_EN
        irq_ack             = 1'b0;
`endif
        #1;
        test_reset;
        test_copia_basica;
        test_cantidad_cero;
        test_error_rango;
        test_pausa_grant;
        test_reset_asincrono;
`ifdef DMA_IRQ_EN
        test_irq;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
